// File: rtl/acc_stream_pkg.sv
// acc_stream_pkg: shared definitions for the acc_stream frame accumulator.
//   state_t       - frame FSM states
//   ADDR_*        - cfg register byte addresses
//   CTRL_*        - bit positions inside the CTRL register
package acc_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_FRAME_CNT = 8'h08;
  localparam logic [7:0] ADDR_OVF_CNT   = 8'h0C;
  localparam logic [7:0] ADDR_PEAK      = 8'h10;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_SAT = 1;
  localparam int CTRL_CLR = 2;

endpackage

// File: rtl/acc_len_fifo.sv
// acc_len_fifo: LEN_W x LEN_DEPTH synchronous FIFO holding pending frame lengths.
//   clk, rst_n   - clock, asynchronous active-low reset (empties the FIFO)
//   push, din    - write request and data (ignored when full)
//   pop          - read request (ignored when empty); head is valid while !empty
//   head         - oldest entry
//   full, empty  - occupancy flags
//   count        - number of stored entries
module acc_len_fifo
  import acc_stream_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int LEN_DEPTH = 4,
  localparam int PTR_W    = $clog2(LEN_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [LEN_W-1:0] din,
  input  logic             pop,
  output logic [LEN_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [LEN_W-1:0] mem [LEN_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(LEN_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because LEN_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/acc_stream.sv
// acc_stream: sums exactly len data words per frame and presents each sum on dout.
//   CLK, RST_N                  - clock, asynchronous active-low reset
//   len_value/len_en/len_rdy    - frame-length push into a LEN_DEPTH queue
//   din_value/din_en/din_rdy    - data words of the current frame
//   dout_value/dout_en/dout_rdy - held frame sum, popped by dout_en
//   cfg_*                       - 32-bit register port (CTRL, STATUS, FRAME_CNT,
//                                 OVF_CNT; read data combinational from cfg_address)
// Optional: define ACC_STREAM_PEAK_EN to add the PEAK register at 0x10.
module acc_stream
  import acc_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 8,
  parameter int LEN_W     = 8,
  parameter int LEN_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] din_value,
  input  logic              din_en,
  output logic              din_rdy,
  input  logic              dout_en,
  output logic [SUM_W-1:0]  dout_value,
  output logic              dout_rdy,
  input  logic [LEN_W-1:0]  len_value,
  input  logic              len_en,
  output logic              len_rdy,
  input  logic [7:0]        cfg_address,
  input  logic [31:0]       cfg_data_in,
  input  logic              cfg_op,
  input  logic              cfg_en,
  output logic [31:0]       cfg_data_out,
  output logic              cfg_rdy
);

  localparam int CNT_W = $clog2(LEN_DEPTH) + 1;

  // Unsigned add of one word with the carry out of SUM_W kept in the top bit.
  function automatic logic [SUM_W:0] add_carry(input logic [SUM_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return {1'b0, a} + (SUM_W+1)'(b);
  endfunction

  // Clamp to all-ones on carry when saturating, otherwise drop the carry (wrap).
  function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W:0] s, input logic sat);
    if (sat && s[SUM_W]) return '1;
    return s[SUM_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic               ready_q;
  logic               ctrl_en, ctrl_sat;
  logic [LEN_W-1:0]   remaining;
  logic [SUM_W-1:0]   acc_p0;
  logic               frame_ovf_p0;
  logic [SUM_W-1:0]   out_sum_p1;
  logic               vld_p1;
  logic [31:0]        frame_cnt, ovf_cnt;

  logic               q_push, q_pop, q_full, q_empty;
  logic [LEN_W-1:0]   q_head;
  logic [CNT_W-1:0]   q_count;

  logic               start, load_zero, final_word, din_fire;
  logic [SUM_W:0]     sum_ext;
  logic [SUM_W-1:0]   sum_next;
  logic               ctrl_wr, clr;
  logic               unused_cfg;

  assign sum_ext    = add_carry(acc_p0, din_value);
  assign sum_next   = sat_sum(sum_ext, ctrl_sat);
  assign ctrl_wr    = ready_q & cfg_en & cfg_op & (cfg_address == ADDR_CTRL);
  assign clr        = ctrl_wr & cfg_data_in[CTRL_CLR];
  assign unused_cfg = ^cfg_data_in[31:3];

  assign len_rdy    = ready_q & ~q_full;
  assign cfg_rdy    = ready_q;
  assign q_push     = len_en & len_rdy;
  assign dout_rdy   = vld_p1;
  assign dout_value = out_sum_p1;

  acc_len_fifo #(
    .LEN_W     (LEN_W),
    .LEN_DEPTH (LEN_DEPTH)
  ) u_len_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (q_push),
    .din   (len_value),
    .pop   (q_pop),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A zero-length frame only completes into an empty output register; a
  // non-zero frame may start while a sum is held, and only its last word waits.
  always_comb begin
    state_d    = state_q;
    q_pop      = 1'b0;
    start      = 1'b0;
    load_zero  = 1'b0;
    final_word = 1'b0;
    din_rdy    = 1'b0;
    din_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en && !q_empty) begin
          if (q_head == '0) begin
            if (!vld_p1) begin
              q_pop     = 1'b1;
              load_zero = 1'b1;
            end
          end else begin
            q_pop   = 1'b1;
            start   = 1'b1;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        din_rdy  = ctrl_en && ((remaining > LEN_W'(1)) || !vld_p1);
        din_fire = din_en && din_rdy;
        if (din_fire && remaining == LEN_W'(1)) begin
          final_word = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: accumulate words of the current frame ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      remaining    <= '0;
      acc_p0       <= '0;
      frame_ovf_p0 <= 1'b0;
    end else if (start) begin
      remaining    <= q_head;
      acc_p0       <= '0;
      frame_ovf_p0 <= 1'b0;
    end else if (din_fire) begin
      remaining    <= remaining - LEN_W'(1);
      acc_p0       <= sum_next;
      frame_ovf_p0 <= frame_ovf_p0 | sum_ext[SUM_W];
    end
  end

  // ---- stage p1: held frame sum, control and counters ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ready_q    <= 1'b0;
      out_sum_p1 <= '0;
      vld_p1     <= 1'b0;
      ctrl_en    <= 1'b1;
      ctrl_sat   <= 1'b0;
      frame_cnt  <= '0;
      ovf_cnt    <= '0;
    end else begin
      ready_q <= 1'b1;
      if (dout_en && vld_p1) vld_p1 <= 1'b0;
      if (load_zero) begin
        out_sum_p1 <= '0;
        vld_p1     <= 1'b1;
      end else if (final_word) begin
        out_sum_p1 <= sum_next;
        vld_p1     <= 1'b1;
      end
      if (ctrl_wr) begin
        ctrl_en  <= cfg_data_in[CTRL_EN];
        ctrl_sat <= cfg_data_in[CTRL_SAT];
      end
      if (clr) begin
        frame_cnt <= '0;
        ovf_cnt   <= '0;
      end else begin
        if (load_zero || final_word) frame_cnt <= frame_cnt + 32'd1;
        if (final_word && (frame_ovf_p0 || sum_ext[SUM_W])) ovf_cnt <= ovf_cnt + 32'd1;
      end
    end
  end

`ifdef ACC_STREAM_PEAK_EN
  logic [DATA_W-1:0] peak_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                              peak_q <= '0;
    else if (clr)                            peak_q <= '0;
    else if (din_fire && din_value > peak_q) peak_q <= din_value;
  end
`endif

  always_comb begin
    cfg_data_out = '0;
    if (ready_q) begin
      case (cfg_address)
        ADDR_CTRL: begin
          cfg_data_out[CTRL_EN]  = ctrl_en;
          cfg_data_out[CTRL_SAT] = ctrl_sat;
        end
        ADDR_STATUS: begin
          cfg_data_out[0]    = (state_q == ACCUM);
          cfg_data_out[1]    = vld_p1;
          cfg_data_out[15:8] = 8'(q_count);
        end
        ADDR_FRAME_CNT: cfg_data_out = frame_cnt;
        ADDR_OVF_CNT:   cfg_data_out = ovf_cnt;
`ifdef ACC_STREAM_PEAK_EN
        ADDR_PEAK:      cfg_data_out = 32'(peak_q);
`endif
        default:        cfg_data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_stream.sv
module tb_acc_stream;

  localparam int DW = 8;
  localparam int SW = 8;
  localparam int LW = 8;
  localparam int LD = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [DW-1:0] din_value;
  logic          din_en;
  logic          din_rdy;
  logic          dout_en;
  logic [SW-1:0] dout_value;
  logic          dout_rdy;
  logic [LW-1:0] len_value;
  logic          len_en;
  logic          len_rdy;
  logic [7:0]    cfg_address;
  logic [31:0]   cfg_data_in;
  logic          cfg_op;
  logic          cfg_en;
  logic [31:0]   cfg_data_out;
  logic          cfg_rdy;

  acc_stream #(.DATA_W(DW), .SUM_W(SW), .LEN_W(LW), .LEN_DEPTH(LD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  int            q[$];        // pending frame lengths
  bit            live;        // at least one clock seen since reset release
  bit            m_en, m_sat;
  bit            busy;        // a frame has been started and not yet completed
  int            rem;         // words still owed by that frame
  longint        tot;         // exact (unbounded) sum of its words so far
  bit            held;
  bit [SW-1:0]   held_val;
  bit [31:0]     fcnt, ocnt;
  bit [DW-1:0]   mpeak;

  task automatic model_reset();
    q.delete();
    live = 0; m_en = 1; m_sat = 0; busy = 0; rem = 0; tot = 0;
    held = 0; held_val = '0; fcnt = '0; ocnt = '0; mpeak = '0;
  endtask

  function automatic bit m_din_rdy();
    return live && busy && m_en && (rem > 1 || !held);
  endfunction

  function automatic bit m_len_rdy();
    return live && (q.size() < LD);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] r;
    r = '0;
    if (!live) return r;
    case (a)
      8'h00: r = {30'd0, m_sat, m_en};
      8'h04: r = {16'd0, 8'(q.size()), 6'd0, held, busy};
      8'h08: r = fcnt;
      8'h0C: r = ocnt;
`ifdef ACC_STREAM_PEAK_EN
      8'h10: r = 32'(mpeak);
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Applies one clock edge's worth of accepted transactions.
  task automatic model_clock();
    bit     old_busy, old_held;
    longint mx;
    mx       = (64'd1 << SW) - 1;
    old_busy = busy;
    old_held = held;
    if (dout_en) held = 0;
    if (old_busy && din_en) begin
      tot += din_value;
      if (din_value > mpeak) mpeak = din_value;
      if (rem == 1) begin
        held     = 1;
        held_val = m_sat ? SW'((tot > mx) ? mx : tot) : SW'(tot & mx);
        fcnt++;
        if (tot > mx) ocnt++;
        busy = 0;
      end
      rem--;
    end
    if (live && !old_busy && q.size() > 0 && m_en) begin
      if (q[0] == 0) begin
        if (!old_held) begin
          void'(q.pop_front());
          held = 1; held_val = '0; fcnt++;
        end
      end else begin
        rem = q.pop_front(); busy = 1; tot = 0;
      end
    end
    if (len_en) q.push_back(int'(len_value));
    if (live && cfg_en && cfg_op && cfg_address == 8'h00) begin
      m_en  = cfg_data_in[0];
      m_sat = cfg_data_in[1];
      if (cfg_data_in[2]) begin fcnt = '0; ocnt = '0; mpeak = '0; end
    end
    live = 1;
  endtask

  task automatic check_outputs();
    chk("din_rdy", din_rdy, m_din_rdy());
    chk("len_rdy", len_rdy, m_len_rdy());
    chk("dout_rdy", dout_rdy, held);
    if (held) chk("dout_value", dout_value, held_val);
    chk("cfg_rdy", cfg_rdy, live);
    chk("cfg_read", cfg_data_out, m_read(cfg_address));
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge CLK);
    model_clock();
    @(negedge CLK);
  endtask

  task automatic clr_in();
    len_en = 0; din_en = 0; dout_en = 0; cfg_en = 0; cfg_op = 0;
  endtask

  task automatic push_len(input int v);
    for (int i = 0; i < 100; i++) begin
      if (m_len_rdy()) begin
        len_en = 1; len_value = LW'(v); tick(); len_en = 0;
        return;
      end
      tick();
    end
    chk("push_timeout", 1, 0);
  endtask

  task automatic send(input int v);
    for (int i = 0; i < 100; i++) begin
      if (m_din_rdy()) begin
        din_en = 1; din_value = DW'(v); tick(); din_en = 0;
        return;
      end
      tick();
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic pop_out();
    for (int i = 0; i < 100; i++) begin
      if (held) begin
        dout_en = 1; tick(); dout_en = 0;
        return;
      end
      tick();
    end
    chk("pop_timeout", 1, 0);
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    cfg_en = 1; cfg_op = 1; cfg_address = 8'h00; cfg_data_in = d;
    tick();
    cfg_en = 0; cfg_op = 0;
  endtask

  task automatic rd_lit(input string nm, input logic [7:0] a, input logic [31:0] exp);
    cfg_address = a;
    #1;
    chk(nm, cfg_data_out, exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (q.size() == 0 && !busy && !held) return;
      din_en    = m_din_rdy();
      din_value = DW'($urandom_range(0, 255));
      dout_en   = held;
      tick();
      clr_in();
    end
    chk("drain_timeout", 1, 0);
  endtask

  task automatic rand_phase(input bit sat, input int n);
    logic [7:0] addrs [6];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
    wr_ctrl({30'd0, sat, 1'b1});
    for (int i = 0; i < n; i++) begin
      int r;
      len_en    = m_len_rdy() && ($urandom_range(0, 2) == 0);
      len_value = LW'($urandom_range(0, 5));
      din_en    = m_din_rdy() && ($urandom_range(0, 3) != 0);
      din_value = DW'($urandom_range(0, 255));
      dout_en   = held && ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 19);
      cfg_address = addrs[$urandom_range(0, 5)];
      if (r == 0) begin
        cfg_en = 1; cfg_op = 1; cfg_address = 8'h00;
        cfg_data_in = {29'd0, ($urandom_range(0, 3) == 0), sat, ($urandom_range(0, 3) != 0)};
      end else if (r == 1) begin
        cfg_en = 1; cfg_op = 1; cfg_address = addrs[$urandom_range(1, 5)];
        cfg_data_in = $urandom;
      end else begin
        cfg_en = 1; cfg_op = 0;
      end
      tick();
      clr_in();
    end
    wr_ctrl({30'd0, sat, 1'b1});
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 0; clr_in();
    din_value = '0; len_value = '0; cfg_address = 8'h00; cfg_data_in = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_dout_rdy", dout_rdy, 0);
    chk("rst_dout_value", dout_value, 0);
    chk("rst_len_rdy", len_rdy, 0);
    chk("rst_cfg_rdy", cfg_rdy, 0);
    chk("rst_cfg_out", cfg_data_out, 0);
    @(negedge CLK);
    RST_N = 1;
    tick();
    rd_lit("ctrl_after_reset", 8'h00, 32'h1);

    // Basic frame: 10+20+30
    push_len(3);
    send(10); send(20); send(30);
    #1;
    chk("t1_dout_rdy", dout_rdy, 1);
    chk("t1_sum", dout_value, 60);
    rd_lit("t1_frame_cnt", 8'h08, 1);
    pop_out();

    // Wrap then saturate: 200+100
    wr_ctrl(32'h1);
    push_len(2); send(200); send(100);
    #1 chk("t2_wrap", dout_value, 44);
    rd_lit("t2_ovf1", 8'h0C, 1);
    pop_out();
    wr_ctrl(32'h3);
    push_len(2); send(200); send(100);
    #1 chk("t2_sat", dout_value, 255);
    rd_lit("t2_ovf2", 8'h0C, 2);
    pop_out();
    wr_ctrl(32'h1);

    // Lengths 0,1,2 back to back with the zero sum held
    push_len(0); push_len(1); push_len(2);
    tick(); tick();
    #1;
    chk("t3_held_rdy", dout_rdy, 1);
    chk("t3_held_zero", dout_value, 0);
    chk("t3_last_stall", din_rdy, 0);
    rd_lit("t3_status", 8'h04, 32'h0000_0103);
    pop_out();
    send(5);
    #1 chk("t3_len1_sum", dout_value, 5);
    pop_out();
    send(1); send(2);
    #1 chk("t3_len2_sum", dout_value, 3);
    pop_out();
    wr_ctrl(32'h0);
    push_len(2); push_len(1); push_len(2); push_len(1);
    #1 chk("t3_full", len_rdy, 0);
    rd_lit("t3_status_full", 8'h04, 32'h0000_0400);
    wr_ctrl(32'h1);
    drain();

    // Enable stall mid-frame
    push_len(4); send(11); send(12);
    wr_ctrl(32'h0);
    #1 chk("t4_stall", din_rdy, 0);
    rd_lit("t4_busy", 8'h04, 32'h1);
    tick(); tick();
    wr_ctrl(32'h1);
    send(5); send(5);
    #1 chk("t4_sum", dout_value, 33);
    pop_out();

    rand_phase(1'b0, 400);
    rand_phase(1'b1, 400);
    wr_ctrl(32'h1);

    // Asynchronous reset mid-frame
    push_len(4); send(9);
    #3 RST_N = 0;
    #1;
    chk("arst_din_rdy", din_rdy, 0);
    chk("arst_dout_rdy", dout_rdy, 0);
    chk("arst_dout_value", dout_value, 0);
    chk("arst_len_rdy", len_rdy, 0);
    chk("arst_cfg_rdy", cfg_rdy, 0);
    chk("arst_cfg_out", cfg_data_out, 0);
    model_reset();
    clr_in();
    repeat (2) @(negedge CLK);
    RST_N = 1;
    tick();
    rd_lit("arst_status", 8'h04, 32'h0);
    rd_lit("arst_ctrl", 8'h00, 32'h1);
    tick();

    // Peak and CLR
    push_len(3); send(7); send(250); send(3);
    #1 chk("pk_sum", dout_value, 260 % 256);
    pop_out();
`ifdef ACC_STREAM_PEAK_EN
    rd_lit("pk_peak", 8'h10, 250);
`else
    rd_lit("pk_absent", 8'h10, 0);
`endif
    rd_lit("pk_fcnt", 8'h08, 1);
    wr_ctrl(32'h5);
    rd_lit("clr_peak", 8'h10, 0);
    rd_lit("clr_fcnt", 8'h08, 0);
    rd_lit("clr_ovf", 8'h0C, 0);
    rd_lit("clr_ctrl", 8'h00, 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
